// File: rtl/ram_arb_pkg.sv
// Shared types for the ram_arb RAM: FSM states and array-port select encodings.
package ram_arb_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CPU  = 2'd1,
        SEL_AUX  = 2'd2
    } sel_t;

endpackage

// File: rtl/ram_sp_core.sv
// Single-port DW x DEPTH array with registered read-first output.
// Not reset; contents survive reset.
module ram_sp_core #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter     RAM_FILENAME = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] dout_q;

  // Read samples the old word before the write lands (read-first).
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ram_arb.sv
// System RAM shared by a never-stalled CPU port and a req/ack aux port, with
// optional fill-after-reset and a write-protected address window.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 13,
    parameter                        RAM_FILENAME  = "",
    parameter bit                    FILL_ON_RESET = 1'b0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = '0,
    parameter logic [ADDR_WIDTH-1:0] WP_BASE       = ADDR_WIDTH'('h1F00),
    parameter logic [ADDR_WIDTH-1:0] WP_TOP        = ADDR_WIDTH'('h1FFF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_din,
    output logic [DATA_WIDTH-1:0] aux_dout,
    output logic                  aux_ack,
    input  logic                  wp_en,
    output logic                  wp_violation,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam state_t RESET_STATE = FILL_ON_RESET ? ST_FILL : ST_RUN;

    state_t                  state_q, state_d;
    sel_t                    sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [DATA_WIDTH-1:0]   cpu_hold_q, cpu_hold_d;
    logic [DATA_WIDTH-1:0]   aux_hold_q, aux_hold_d;
    logic                    wp_viol_q, wp_viol_d;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;
    logic [DATA_WIDTH-1:0]   core_dout;
    logic                    cpu_wp_hit;
    logic                    aux_wp_hit;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        return (a >= WP_BASE) && (a <= WP_TOP);
    endfunction

    assign cpu_wp_hit = wp_en && cpu_we && in_window(cpu_addr);
    assign aux_wp_hit = wp_en && aux_we && in_window(aux_addr);

    // aux_ack is the registered "aux was granted last cycle" select; it also
    // blocks a regrant so the requester gets a dead cycle to drop aux_req.
    assign aux_ack      = (sel_q == SEL_AUX);
    assign busy         = (state_q == ST_FILL);
    assign wp_violation = wp_viol_q;
    assign cpu_dout     = (sel_q == SEL_CPU) ? core_dout : cpu_hold_q;
    assign aux_dout     = (sel_q == SEL_AUX) ? core_dout : aux_hold_q;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        sel_d      = SEL_NONE;
        wp_viol_d  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_din    = cpu_din;

        case (state_q)
            ST_FILL: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = fill_cnt_q;
                mem_din    = FILL_VALUE;
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (cpu_en) begin
                    sel_d     = SEL_CPU;
                    mem_en    = 1'b1;
                    mem_we    = cpu_we && !cpu_wp_hit;
                    mem_addr  = cpu_addr;
                    mem_din   = cpu_din;
                    wp_viol_d = cpu_wp_hit;
                end else if (aux_req && !aux_ack) begin
                    sel_d     = SEL_AUX;
                    mem_en    = 1'b1;
                    mem_we    = aux_we && !aux_wp_hit;
                    mem_addr  = aux_addr;
                    mem_din   = aux_din;
                    wp_viol_d = aux_wp_hit;
                end
            end
        endcase
    end

    always_comb begin
        cpu_hold_d = cpu_hold_q;
        aux_hold_d = aux_hold_q;
        if (sel_q == SEL_CPU) begin
            cpu_hold_d = core_dout;
        end
        if (sel_q == SEL_AUX) begin
            aux_hold_d = core_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            sel_q      <= SEL_NONE;
            fill_cnt_q <= '0;
            cpu_hold_q <= '0;
            aux_hold_q <= '0;
            wp_viol_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            fill_cnt_q <= fill_cnt_d;
            cpu_hold_q <= cpu_hold_d;
            aux_hold_q <= aux_hold_d;
            wp_viol_q  <= wp_viol_d;
        end
    end

    ram_sp_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RAM_FILENAME (RAM_FILENAME)
    ) u_core (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (core_dout)
    );

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: a run-mode instance (13-bit, no fill) and a fill-mode
// instance (4-bit, fill with A5), sharing one clock.
module tb_ram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    // run-mode instance
    logic        r_rst_n = 1'b0;
    logic        r_cpu_en = 1'b0, r_cpu_we = 1'b0;
    logic [12:0] r_cpu_addr = '0;
    logic [7:0]  r_cpu_din = '0, r_cpu_dout;
    logic        r_aux_req = 1'b0, r_aux_we = 1'b0;
    logic [12:0] r_aux_addr = '0;
    logic [7:0]  r_aux_din = '0, r_aux_dout;
    logic        r_aux_ack, r_wp_en = 1'b0, r_wp_violation, r_busy;

    // fill-mode instance
    logic        f_rst_n = 1'b0;
    logic        f_cpu_en = 1'b0, f_cpu_we = 1'b0;
    logic [3:0]  f_cpu_addr = '0;
    logic [7:0]  f_cpu_din = '0, f_cpu_dout;
    logic        f_aux_req = 1'b0, f_aux_we = 1'b0;
    logic [3:0]  f_aux_addr = '0;
    logic [7:0]  f_aux_din = '0, f_aux_dout;
    logic        f_aux_ack, f_wp_en = 1'b0, f_wp_violation, f_busy;

    ram_arb #(
        .DATA_WIDTH(8), .ADDR_WIDTH(13), .FILL_ON_RESET(1'b0)
    ) dut_run (
        .clk(clk), .rst_n(r_rst_n),
        .cpu_en(r_cpu_en), .cpu_addr(r_cpu_addr), .cpu_we(r_cpu_we),
        .cpu_din(r_cpu_din), .cpu_dout(r_cpu_dout),
        .aux_req(r_aux_req), .aux_we(r_aux_we), .aux_addr(r_aux_addr),
        .aux_din(r_aux_din), .aux_dout(r_aux_dout), .aux_ack(r_aux_ack),
        .wp_en(r_wp_en), .wp_violation(r_wp_violation), .busy(r_busy)
    );

    ram_arb #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FILL_ON_RESET(1'b1),
        .FILL_VALUE(8'hA5), .WP_BASE(4'hE), .WP_TOP(4'hF)
    ) dut_fill (
        .clk(clk), .rst_n(f_rst_n),
        .cpu_en(f_cpu_en), .cpu_addr(f_cpu_addr), .cpu_we(f_cpu_we),
        .cpu_din(f_cpu_din), .cpu_dout(f_cpu_dout),
        .aux_req(f_aux_req), .aux_we(f_aux_we), .aux_addr(f_aux_addr),
        .aux_din(f_aux_din), .aux_dout(f_aux_dout), .aux_ack(f_aux_ack),
        .wp_en(f_wp_en), .wp_violation(f_wp_violation), .busy(f_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_wait_ack(output logic got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r_aux_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  din;
        logic        wp;
        logic        chk;
        logic [7:0]  exp_dout;
        logic        exp_wp;
    } vec_t;

    vec_t vecs[17];
    logic [7:0] model[16];

    task automatic fill_count_busy(output int cycles, output logic clean);
        cycles = 0;
        clean  = 1'b1;
        while (f_busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (f_busy && (f_aux_ack || f_cpu_dout != 8'h00)) clean = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic       got;
        logic       clean;
        int         cyc;
        logic [7:0] e;
        logic [3:0] a;
        logic [7:0] d;
        logic       w;

        //                en  we  addr      din    wp  chk exp    exp_wp
        vecs[0]  = '{1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 13'h0040, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 13'h0040, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 13'h0040, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 13'h1F80, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 13'h1F80, 8'h77, 1'b1, 1'b1, 8'h42, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 13'h1F80, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 13'h1F80, 8'h77, 1'b0, 1'b1, 8'h42, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 13'h1F80, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 13'h1EFF, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 13'h1EFF, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 13'h1FFF, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 13'h1F00, 8'h66, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 13'h0010, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0};

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        check("rst_cpu_dout", 32'(r_cpu_dout), 32'h0);
        check("rst_aux_dout", 32'(r_aux_dout), 32'h0);
        check("rst_aux_ack", 32'(r_aux_ack), 32'h0);
        check("rst_wp", 32'(r_wp_violation), 32'h0);
        check("rst_busy_run", 32'(r_busy), 32'h0);
        check("rst_busy_fill", 32'(f_busy), 32'h1);
        r_rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 17; i++) begin
            r_cpu_en   = vecs[i].en;
            r_cpu_we   = vecs[i].we;
            r_cpu_addr = vecs[i].addr;
            r_cpu_din  = vecs[i].din;
            r_wp_en    = vecs[i].wp;
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp_dout);
            @(negedge clk);
            if (vecs[i].chk) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d_dout", i), 32'(r_cpu_dout), 32'(e));
            end
            check($sformatf("vec%0d_wp", i), 32'(r_wp_violation), 32'(vecs[i].exp_wp));
        end
        r_cpu_en = 1'b0;
        r_wp_en  = 1'b0;

        // ---------------- random CPU traffic vs model ----------------
        for (int i = 0; i < 16; i++) begin
            model[i]   = 8'($urandom_range(0, 255));
            r_cpu_en   = 1'b1;
            r_cpu_we   = 1'b1;
            r_cpu_addr = 13'h0200 + 13'(i);
            r_cpu_din  = model[i];
            @(negedge clk);
        end
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            r_cpu_we   = w;
            r_cpu_addr = 13'h0200 + 13'(a);
            r_cpu_din  = d;
            exp_q.push_back(model[a]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("rand%0d", i), 32'(r_cpu_dout), 32'(e));
            if (w) model[a] = d;
        end
        r_cpu_en = 1'b0;
        r_cpu_we = 1'b0;
        @(negedge clk);

        // ---------------- contention: CPU wins ----------------
        r_cpu_en   = 1'b1;
        r_cpu_addr = 13'h0123;
        r_aux_req  = 1'b1;
        r_aux_we   = 1'b0;
        r_aux_addr = 13'h0010;
        @(negedge clk);
        check("cont_ack_a", 32'(r_aux_ack), 32'h0);
        check("cont_cpu_a", 32'(r_cpu_dout), 32'h5A);
        r_cpu_addr = 13'h0040;
        @(negedge clk);
        check("cont_ack_b", 32'(r_aux_ack), 32'h0);
        check("cont_cpu_b", 32'(r_cpu_dout), 32'h33);
        r_cpu_en = 1'b0;
        @(negedge clk);
        check("cont_ack_c", 32'(r_aux_ack), 32'h1);
        check("cont_aux_dout", 32'(r_aux_dout), 32'hC3);
        check("cont_cpu_hold", 32'(r_cpu_dout), 32'h33);
        r_aux_req = 1'b0;
        @(negedge clk);
        check("cont_ack_d", 32'(r_aux_ack), 32'h0);
        check("cont_aux_hold", 32'(r_aux_dout), 32'hC3);

        // ---------------- req held through ack: dead cycle ----------------
        r_aux_req  = 1'b1;
        r_aux_addr = 13'h0123;
        @(negedge clk);
        check("hold_ack1", 32'(r_aux_ack), 32'h1);
        check("hold_dout1", 32'(r_aux_dout), 32'h5A);
        @(negedge clk);
        check("hold_dead", 32'(r_aux_ack), 32'h0);
        @(negedge clk);
        check("hold_ack2", 32'(r_aux_ack), 32'h1);
        r_aux_req = 1'b0;
        @(negedge clk);
        check("hold_ack_drop", 32'(r_aux_ack), 32'h0);

        // ---------------- aux write, then CPU read-back ----------------
        r_aux_req  = 1'b1;
        r_aux_we   = 1'b1;
        r_aux_addr = 13'h0300;
        r_aux_din  = 8'h6D;
        run_wait_ack(got);
        check("auxwr_ack", 32'(got), 32'h1);
        r_aux_req = 1'b0;
        r_aux_we  = 1'b0;
        r_cpu_en   = 1'b1;
        r_cpu_we   = 1'b0;
        r_cpu_addr = 13'h0300;
        @(negedge clk);
        check("auxwr_readback", 32'(r_cpu_dout), 32'h6D);
        r_cpu_en = 1'b0;

        // ---------------- aux write into protected window ----------------
        r_wp_en    = 1'b1;
        r_aux_req  = 1'b1;
        r_aux_we   = 1'b1;
        r_aux_addr = 13'h1F80;
        r_aux_din  = 8'h00;
        run_wait_ack(got);
        check("auxwp_ack", 32'(got), 32'h1);
        check("auxwp_viol", 32'(r_wp_violation), 32'h1);
        r_aux_req = 1'b0;
        r_aux_we  = 1'b0;
        r_cpu_en   = 1'b1;
        r_cpu_addr = 13'h1F80;
        @(negedge clk);
        check("auxwp_readback", 32'(r_cpu_dout), 32'h77);
        check("auxwp_pulse_end", 32'(r_wp_violation), 32'h0);
        r_cpu_en = 1'b0;
        r_wp_en  = 1'b0;

        // ---------------- fill after reset ----------------
        f_aux_req  = 1'b1;
        f_aux_we   = 1'b0;
        f_aux_addr = 4'h3;
        f_cpu_en   = 1'b1;
        f_cpu_we   = 1'b1;
        f_cpu_addr = 4'h5;
        f_cpu_din  = 8'h3C;
        @(negedge clk);
        f_rst_n = 1'b1;
        fill_count_busy(cyc, clean);
        f_cpu_en = 1'b0;
        f_cpu_we = 1'b0;
        check("fill_cycles", 32'(cyc), 32'd16);
        check("fill_blocked", 32'(clean), 32'h1);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (f_aux_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("fill_aux_ack", 32'(got), 32'h1);
        check("fill_aux_dout", 32'(f_aux_dout), 32'hA5);
        f_aux_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f_cpu_en   = 1'b1;
            f_cpu_addr = 4'(i);
            exp_q.push_back(8'hA5);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("fill_rd%0d", i), 32'(f_cpu_dout), 32'(e));
        end
        f_cpu_en = 1'b0;

        // ---------------- async reset from run, then mid-fill ----------------
        f_rst_n = 1'b0;
        #1;
        check("areset_run_cpu", 32'(f_cpu_dout), 32'h0);
        check("areset_run_aux", 32'(f_aux_dout), 32'h0);
        check("areset_run_busy", 32'(f_busy), 32'h1);
        @(negedge clk);
        f_rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        f_rst_n = 1'b0;
        #1;
        check("areset_fill_busy", 32'(f_busy), 32'h1);
        check("areset_fill_ack", 32'(f_aux_ack), 32'h0);
        check("areset_fill_cpu", 32'(f_cpu_dout), 32'h0);
        check("areset_fill_aux", 32'(f_aux_dout), 32'h0);
        check("areset_fill_wp", 32'(f_wp_violation), 32'h0);
        @(negedge clk);
        f_rst_n = 1'b1;
        fill_count_busy(cyc, clean);
        check("refill_cycles", 32'(cyc), 32'd16);
        @(negedge clk);
        f_cpu_en   = 1'b1;
        f_cpu_addr = 4'h7;
        @(negedge clk);
        check("refill_rd7", 32'(f_cpu_dout), 32'hA5);
        f_cpu_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
